// File: rtl/sev_seg_bcd_conv.sv
// sev_seg_bcd_conv: sequential binary-to-BCD converter (double-dabble, one
// bit per clock) with optional two's-complement sign handling.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in                binary value, sampled when a load is accepted
//   load              conversion request
//   twos_complement   1 = treat in as signed
//   busy              conversion in progress (state SHIFT)
//   valid             one-cycle pulse, bcd/neg just updated (state DONE)
//   bcd               packed BCD result, digit 0 in bits [3:0]
//   neg               sign of the last completed conversion
//
// Optional feature macro: SEV_SEG_BCD_PENDING_EN
//   defined   -> single-entry pending buffer catches loads during SHIFT
//   undefined -> loads during SHIFT are dropped
module sev_seg_bcd_conv #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      in,
    input  logic                  load,
    input  logic                  twos_complement,
    output logic                  busy,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  neg
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    generate
        if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
            $error("sev_seg_bcd_conv: WIDTH must be 4..16");
        end
        if (pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_digits
            $error("sev_seg_bcd_conv: DIGITS too small for WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sr_q;
    logic [BW-1:0]    scr_q;
    logic [CW-1:0]    cnt_q;
    logic             sign_q;
    logic [BW-1:0]    bcd_q;
    logic             neg_q;

    logic [BW-1:0]    adj_d;
    logic [BW-1:0]    shift_scr_d;
    logic [WIDTH-1:0] shift_sr_d;
    logic [WIDTH-1:0] src_in_d;
    logic             src_tc_d;
    logic [WIDTH-1:0] start_mag_d;
    logic             start_sign_d;

`ifdef SEV_SEG_BCD_PENDING_EN
    logic             pend_q;
    logic [WIDTH-1:0] pend_in_q;
    logic             pend_tc_q;
`endif

    // Add-3 correction on every digit that would overflow when doubled.
    always_comb begin
        adj_d = scr_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (scr_q[4*d +: 4] >= 4'd5) begin
                adj_d[4*d +: 4] = scr_q[4*d +: 4] + 4'd3;
            end
        end
    end

    assign shift_scr_d = {adj_d[BW-2:0], sr_q[WIDTH-1]};
    assign shift_sr_d  = {sr_q[WIDTH-2:0], 1'b0};

    // A fresh load always wins over a buffered request.
`ifdef SEV_SEG_BCD_PENDING_EN
    assign src_in_d = load ? in : pend_in_q;
    assign src_tc_d = load ? twos_complement : pend_tc_q;
`else
    assign src_in_d = in;
    assign src_tc_d = twos_complement;
`endif

    // Negation of the most negative value wraps to its unsigned magnitude,
    // so 8'h80 becomes 128 without needing an extra bit.
    assign start_sign_d = src_tc_d & src_in_d[WIDTH-1];
    assign start_mag_d  = start_sign_d ? (~src_in_d + 1'b1) : src_in_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            bcd_q   <= '0;
            neg_q   <= 1'b0;
`ifdef SEV_SEG_BCD_PENDING_EN
            pend_q    <= 1'b0;
            pend_in_q <= '0;
            pend_tc_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (load) begin
                        sr_q    <= start_mag_d;
                        sign_q  <= start_sign_d;
                        scr_q   <= '0;
                        cnt_q   <= CW'(WIDTH);
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    scr_q <= shift_scr_d;
                    sr_q  <= shift_sr_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        bcd_q   <= shift_scr_d;
                        neg_q   <= sign_q;
                        state_q <= DONE;
                    end
`ifdef SEV_SEG_BCD_PENDING_EN
                    if (load) begin
                        pend_q    <= 1'b1;
                        pend_in_q <= in;
                        pend_tc_q <= twos_complement;
                    end
`endif
                end
                DONE: begin
`ifdef SEV_SEG_BCD_PENDING_EN
                    if (load || pend_q) begin
                        pend_q <= 1'b0;
`else
                    if (load) begin
`endif
                        sr_q    <= start_mag_d;
                        sign_q  <= start_sign_d;
                        scr_q   <= '0;
                        cnt_q   <= CW'(WIDTH);
                        state_q <= SHIFT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy  = (state_q == SHIFT);
    assign valid = (state_q == DONE);
    assign bcd   = bcd_q;
    assign neg   = neg_q;

endmodule

// File: tb/tb_sev_seg_bcd_conv.sv
// tb_sev_seg_bcd_conv: directed self-checking bench for sev_seg_bcd_conv
// (WIDTH=8, DIGITS=3), covering both pending-buffer build options.
module tb_sev_seg_bcd_conv;

    logic        clk;
    logic        rst;
    logic [7:0]  in;
    logic        load;
    logic        twos_complement;
    logic        busy;
    logic        valid;
    logic [11:0] bcd;
    logic        neg;

    int total;
    int bad;

    sev_seg_bcd_conv #(
        .WIDTH  (8),
        .DIGITS (3)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in              (in),
        .load            (load),
        .twos_complement (twos_complement),
        .busy            (busy),
        .valid           (valid),
        .bcd             (bcd),
        .neg             (neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count edges until valid is seen; -1 on timeout.
    task automatic wait_valid(output int n);
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (valid) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic drain(input string tag);
        int ok;
        ok = 0;
        for (int k = 0; k < 40; k++) begin
            if (!busy && !valid) begin
                ok = 1;
                break;
            end
            step();
        end
        chk(tag, ok, 1);
    endtask

    task automatic conv(input string tag, input logic [7:0] v,
                        input logic tc, input logic [11:0] eb,
                        input logic en);
        int n;
        in = v;
        twos_complement = tc;
        load = 1'b1;
        step();
        load = 1'b0;
        in = 8'h5A;
        twos_complement = ~tc;
        chk({tag, "_busy"}, busy, 1);
        wait_valid(n);
        chk({tag, "_lat"}, n, 8);
        chk({tag, "_bcd"}, bcd, eb);
        chk({tag, "_neg"}, neg, en);
        step();
        chk({tag, "_vpulse"}, valid, 0);
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_hold"}, bcd, eb);
    endtask

    initial begin
        int n;
        int saw;
        total = 0;
        bad = 0;
        rst = 1'b1;
        in = 8'h00;
        load = 1'b0;
        twos_complement = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_bcd", bcd, 0);
        chk("rst_neg", neg, 0);

        conv("umax", 8'hFF, 1'b0, 12'h255, 1'b0);
        conv("smin", 8'h80, 1'b1, 12'h128, 1'b1);
        conv("sm1", 8'hFF, 1'b1, 12'h001, 1'b1);
        conv("szero", 8'h00, 1'b1, 12'h000, 1'b0);
        conv("smax", 8'h7F, 1'b1, 12'h127, 1'b0);
        conv("u80", 8'h80, 1'b0, 12'h128, 1'b0);

        // back-to-back with load held high
        in = 8'd99;
        twos_complement = 1'b0;
        load = 1'b1;
        step();
        in = 8'd100;
        wait_valid(n);
        chk("b2b_lat0", n, 8);
        chk("b2b_bcd0", bcd, 12'h099);
        wait_valid(n);
        chk("b2b_gap", n, 9);
        chk("b2b_bcd1", bcd, 12'h100);
        load = 1'b0;
        step();
        drain("b2b_drain");

        // load during SHIFT
        in = 8'h0C;
        load = 1'b1;
        step();
        load = 1'b0;
        step();
        step();
        in = 8'h2A;
        load = 1'b1;
        step();
        load = 1'b0;
        in = 8'h00;
        wait_valid(n);
        chk("pend_lat0", n, 5);
        chk("pend_bcd0", bcd, 12'h012);
`ifdef SEV_SEG_BCD_PENDING_EN
        wait_valid(n);
        chk("pend_gap", n, 9);
        chk("pend_bcd1", bcd, 12'h042);
        step();
        chk("pend_idle", busy, 0);
`else
        saw = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (valid || busy) saw = 1;
        end
        chk("nopend_quiet", saw, 0);
        chk("nopend_bcd", bcd, 12'h012);
`endif

        // reset mid-conversion
        in = 8'hC8;
        load = 1'b1;
        step();
        load = 1'b0;
        repeat (3) step();
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_busy", busy, 0);
        chk("mrst_valid", valid, 0);
        chk("mrst_bcd", bcd, 0);
        chk("mrst_neg", neg, 0);
        saw = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (valid) saw = 1;
        end
        chk("mrst_novalid", saw, 0);
        conv("after_rst", 8'd7, 1'b0, 12'h007, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
